jtdsp16_cond: RTL

//  Condition evaluator and sequencing control for the DAU. Evaluates the 5-bit
//  CON field of conditional instructions (if/ifc/special-function) against
//  the DAU flags, owns counters c0/c1/c2 and the heads/tails pseudorandom

---
 rtl/jtdsp16_cond.sv | 120 ++++++++++++
 1 files changed

// File: rtl/jtdsp16_cond.sv
// DSP16 condition evaluator: CON-code test against DAU flags, c0/c1/c2 counters,
// heads/tails LFSR and the squash-next-instruction control.
module jtdsp16_cond #(
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cen,
  input  logic [4:0] i_c_field,
  input  logic       i_cond_req,
  input  logic       i_is_if,
  input  logic       i_instr_adv,
  input  logic       i_lmi,
  input  logic       i_leq,
  input  logic       i_llv,
  input  logic       i_lmv,
  input  logic [2:0] i_c_we,
  input  logic [7:0] i_c_din,
  output logic       o_cond_true,
  output logic       o_cond_valid,
  output logic       o_skip_next,
  output logic [7:0] o_c0,
  output logic [7:0] o_c1,
  output logic [7:0] o_c2,
  output logic       o_heads
);

  typedef enum logic {ST_RUN, ST_SKIP} state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic       r_cond_true;
  logic       r_cond_valid;
  logic [7:0] r_c0;
  logic [7:0] r_c1;
  logic [7:0] r_c2;
  logic [9:0] r_lfsr;
  logic       w_eval;
  logic       w_res;
  logic       w_inc_c0;
  logic       w_inc_c1;
  logic       w_shift;

  // A condition carried by a squashed instruction is not evaluated at all.
  assign w_eval   = i_cen & i_cond_req & (r_state == ST_RUN);
  assign w_inc_c0 = w_eval & ((i_c_field == 5'd10) | (i_c_field == 5'd11));
  assign w_inc_c1 = w_eval & ((i_c_field == 5'd12) | (i_c_field == 5'd13));
  assign w_shift  = w_eval & ((i_c_field == 5'd8)  | (i_c_field == 5'd9));

  always_comb begin
    w_res = 1'b0;
    case (i_c_field)
      5'd0:    w_res =  i_lmi;
      5'd1:    w_res = ~i_lmi;
      5'd2:    w_res =  i_leq;
      5'd3:    w_res = ~i_leq;
      5'd4:    w_res =  i_llv;
      5'd5:    w_res = ~i_llv;
      5'd6:    w_res =  i_lmv;
      5'd7:    w_res = ~i_lmv;
      5'd8:    w_res =  r_lfsr[0];
      5'd9:    w_res = ~r_lfsr[0];
      5'd10:   w_res = ~r_c0[7];
      5'd11:   w_res =  r_c0[7];
      5'd12:   w_res = ~r_c1[7];
      5'd13:   w_res =  r_c1[7];
      5'd14:   w_res = 1'b1;
      5'd15:   w_res = 1'b0;
      5'd16:   w_res = ~i_lmi & ~i_leq;
      5'd17:   w_res =  i_lmi |  i_leq;
      default: w_res = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_RUN:  if (i_cond_req && i_is_if && !w_res) w_state_nx = ST_SKIP;
      ST_SKIP: if (i_instr_adv) w_state_nx = ST_RUN;
      default: w_state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= ST_RUN;
    else if (i_cen)
      r_state <= w_state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cond_true  <= 1'b0;
      r_cond_valid <= 1'b0;
      r_c0         <= 8'h00;
      r_c1         <= 8'h00;
      r_c2         <= 8'h00;
      r_lfsr       <= LFSR_SEED;
    end else if (i_cen) begin
      r_cond_valid <= w_eval;
      if (w_eval) r_cond_true <= w_res;
      // An explicit write beats the post-test increment.
      if (i_c_we[0])     r_c0 <= i_c_din;
      else if (w_inc_c0) r_c0 <= r_c0 + 8'd1;
      if (i_c_we[1])     r_c1 <= i_c_din;
      else if (w_inc_c1) r_c1 <= r_c1 + 8'd1;
      if (i_c_we[2])     r_c2 <= i_c_din;
      if (w_shift)       r_lfsr <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[9:1]};
    end
  end

  assign o_cond_true  = r_cond_true;
  assign o_cond_valid = r_cond_valid;
  assign o_skip_next  = (r_state == ST_SKIP);
  assign o_c0         = r_c0;
  assign o_c1         = r_c1;
  assign o_c2         = r_c2;
  assign o_heads      = r_lfsr[0];

endmodule
